// File: rtl/noc_output_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_output_port_arbiter_if
//
// Purpose: bundles the per-output-port allocator signals: the NUM_INPUTS
// head-of-queue flit requests from the input buffers, the registered flit
// link towards the downstream router, the credit return path and the
// status/debug outputs.
//
// Handshake semantics (upstream side): req_in[i] is a valid flag for the
// head flit of input i (data_in/dest_in/is_tail_in slice i). pop_out[i] is
// the ready/accept: the flit transfers in a cycle where req_in[i] and
// pop_out[i] are both high. pop_out is one-hot or zero and never asserts
// without the matching req_in. Downstream side: send_out qualifies
// data_out/dest_out/is_tail_out for exactly one cycle per flit; the
// downstream buffer returns one credit_in pulse per freed slot.
//
// Modports:
//   slave  - the arbiter (consumes requests/credits, drives link/status)
//   master - the surrounding router / testbench
//
// Signals:
//   req_in, data_in, dest_in, is_tail_in : per-input head flit
//   pop_out                               : per-input accept
//   data_out, dest_out, is_tail_out       : registered link flit
//   send_out                              : link flit valid
//   credit_in                             : downstream slot freed
//   credits_avail                         : current credit count
//   locked_out                            : FSM state (1 = LOCKED)
//   grant_idx                             : current/last granted input
//   credit_err                            : sticky credit overflow flag
// -----------------------------------------------------------------------------
interface noc_output_port_arbiter_if #(
    parameter int NUM_INPUTS   = 5,
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 6,
    parameter int CREDIT_DEPTH = 8,
    parameter int CNT_WIDTH    = $clog2(CREDIT_DEPTH + 1),
    parameter int IDX_WIDTH    = $clog2(NUM_INPUTS)
);

    logic [NUM_INPUTS-1:0]            req_in;
    logic [NUM_INPUTS*FLIT_WIDTH-1:0] data_in;
    logic [NUM_INPUTS*DEST_WIDTH-1:0] dest_in;
    logic [NUM_INPUTS-1:0]            is_tail_in;
    logic [NUM_INPUTS-1:0]            pop_out;
    logic [FLIT_WIDTH-1:0]            data_out;
    logic [DEST_WIDTH-1:0]            dest_out;
    logic                             is_tail_out;
    logic                             send_out;
    logic                             credit_in;
    logic [CNT_WIDTH-1:0]             credits_avail;
    logic                             locked_out;
    logic [IDX_WIDTH-1:0]             grant_idx;
    logic                             credit_err;

    modport slave (
        input  req_in, data_in, dest_in, is_tail_in, credit_in,
        output pop_out, data_out, dest_out, is_tail_out, send_out,
        output credits_avail, locked_out, grant_idx, credit_err
    );

    modport master (
        output req_in, data_in, dest_in, is_tail_in, credit_in,
        input  pop_out, data_out, dest_out, is_tail_out, send_out,
        input  credits_avail, locked_out, grant_idx, credit_err
    );

endinterface

// File: rtl/noc_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_output_port_arbiter
//
// Purpose: switch allocator for one router output port. Shares the output
// link between NUM_INPUTS input flit buffers using round-robin arbitration
// at packet granularity. Once a multi-flit packet wins, the output stays
// locked to that input (wormhole) until its tail flit has been sent.
// Flits are only popped while the downstream buffer has credits; the
// accepted flit is registered onto the link one cycle later.
//
// Ports:
//   clk_noc  - NoC clock, all state on rising edge
//   rst_noc  - asynchronous active-high reset
//   port_if  - noc_output_port_arbiter_if.slave (requests, link, credits,
//              status; see the interface file for handshake semantics)
//
// The FSM state is visible on port_if.locked_out (1 = LOCKED).
// -----------------------------------------------------------------------------
module noc_output_port_arbiter #(
    parameter int NUM_INPUTS   = 5,
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 6,
    parameter int CREDIT_DEPTH = 8,
    parameter int CNT_WIDTH    = $clog2(CREDIT_DEPTH + 1),
    parameter int IDX_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                        clk_noc,
    input  logic                        rst_noc,
    noc_output_port_arbiter_if.slave    port_if
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    // grant_q doubles as the packet owner while LOCKED.
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [CNT_WIDTH-1:0]   credits_q, credits_d;
    logic                   credit_err_q, credit_err_d;
    logic                   send_q, send_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   tail_q, tail_d;

    logic                   can_send;
    logic                   rr_found;
    logic [IDX_WIDTH-1:0]   rr_winner;
    logic                   pop_any;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic [FLIT_WIDTH-1:0]  sel_data;
    logic [DEST_WIDTH-1:0]  sel_dest;
    logic                   sel_tail;

    // (base + offs) mod NUM_INPUTS, for base < NUM_INPUTS and offs <= NUM_INPUTS.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                      input int unsigned offs);
        logic [IDX_WIDTH:0] sum;
        sum = {1'b0, base} + (IDX_WIDTH+1)'(offs);
        if (sum >= (IDX_WIDTH+1)'(NUM_INPUTS)) begin
            sum = sum - (IDX_WIDTH+1)'(NUM_INPUTS);
        end
        return sum[IDX_WIDTH-1:0];
    endfunction

    // Registered count only: a credit arriving this cycle cannot fund a pop
    // in the same cycle.
    assign can_send = (credits_q != '0);

    // Round-robin search starting at rr_ptr_q; the first requester wins.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        rr_found  = 1'b0;
        rr_winner = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!rr_found && port_if.req_in[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
    end

    // Flit selection from the granted input.
    always_comb begin
        sel_data = port_if.data_in[FLIT_WIDTH-1:0];
        sel_dest = port_if.dest_in[DEST_WIDTH-1:0];
        sel_tail = port_if.is_tail_in[0];
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_idx == IDX_WIDTH'(i)) begin
                sel_data = port_if.data_in[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_dest = port_if.dest_in[i*DEST_WIDTH +: DEST_WIDTH];
                sel_tail = port_if.is_tail_in[i];
            end
        end
    end

    // FSM next state and pop decision.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        pop_any  = 1'b0;
        sel_idx  = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (can_send && rr_found) begin
                    pop_any = 1'b1;
                    sel_idx = rr_winner;
                    grant_d = rr_winner;
                    if (port_if.is_tail_in[rr_winner]) begin
                        // Single-flit packet: arbitration restarts after the winner.
                        rr_ptr_d = wrap_add(rr_winner, 1);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // Only the owner may send; a gap in its requests keeps the lock.
                if (can_send && port_if.req_in[grant_q]) begin
                    pop_any = 1'b1;
                    sel_idx = grant_q;
                    if (port_if.is_tail_in[grant_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(grant_q, 1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Credit counter and sticky overflow flag.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (pop_any && !port_if.credit_in) begin
            credits_d = credits_q - CNT_WIDTH'(1);
        end else if (port_if.credit_in && !pop_any) begin
            if (credits_q == CNT_WIDTH'(CREDIT_DEPTH)) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CNT_WIDTH'(1);
            end
        end
    end

    // Link register: payload holds its last value on idle cycles.
    always_comb begin
        send_d = pop_any;
        data_d = data_q;
        dest_d = dest_q;
        tail_d = tail_q;
        if (pop_any) begin
            data_d = sel_data;
            dest_d = sel_dest;
            tail_d = sel_tail;
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            credits_q    <= CNT_WIDTH'(CREDIT_DEPTH);
            credit_err_q <= 1'b0;
            send_q       <= 1'b0;
            data_q       <= '0;
            dest_q       <= '0;
            tail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            send_q       <= send_d;
            data_q       <= data_d;
            dest_q       <= dest_d;
            tail_q       <= tail_d;
        end
    end

    // pop_out is forced low during reset so upstream never dequeues a flit
    // that the reset is about to discard.
    always_comb begin
        port_if.pop_out = '0;
        if (pop_any && !rst_noc) begin
            port_if.pop_out[sel_idx] = 1'b1;
        end
    end

    assign port_if.data_out      = data_q;
    assign port_if.dest_out      = dest_q;
    assign port_if.is_tail_out   = tail_q;
    assign port_if.send_out      = send_q;
    assign port_if.credits_avail = credits_q;
    assign port_if.locked_out    = (state_q == ST_LOCKED);
    assign port_if.grant_idx     = grant_q;
    assign port_if.credit_err    = credit_err_q;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_output_port_arbiter
//
// Directed bench for noc_output_port_arbiter. Inputs change 1 ns after the
// rising edge; pop_out is sampled 2 ns after, registered outputs 1 ns after.
// Every popped flit is pushed to exp_q and compared on the link one cycle
// later.
// -----------------------------------------------------------------------------
module tb_noc_output_port_arbiter;

    localparam int NI = 5;
    localparam int FW = 64;
    localparam int DW = 6;

    logic clk_noc;
    logic rst_noc;

    noc_output_port_arbiter_if #(
        .NUM_INPUTS(NI), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .CREDIT_DEPTH(8)
    ) bus ();

    noc_output_port_arbiter #(
        .NUM_INPUTS(NI), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .CREDIT_DEPTH(8)
    ) dut (
        .clk_noc (clk_noc),
        .rst_noc (rst_noc),
        .port_if (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_fail;
    int          seq;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] flit_data [NI];
    logic [DW-1:0] flit_dest [NI];
    logic [FW-1:0] last_data;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [NI-1:0] req, input logic [NI-1:0] tail, input logic credit);
        seq++;
        for (int i = 0; i < NI; i++) begin
            flit_data[i] = (64'(i) << 56) | 64'(seq);
            flit_dest[i] = DW'(seq + i);
            bus.data_in[i*FW +: FW] = flit_data[i];
            bus.dest_in[i*DW +: DW] = flit_dest[i];
        end
        bus.req_in     = req;
        bus.is_tail_in = tail;
        bus.credit_in  = credit;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0);
        rst_noc = 1'b1;
        @(posedge clk_noc);
        #1;
        rst_noc   = 1'b0;
        last_data = '0;
        exp_q.delete();
    endtask

    // Called at edge+1 with inputs driven; returns at the next edge+1.
    task automatic run_cycle(input string tag, input logic [NI-1:0] exp_pop);
        int            idx;
        logic [DW-1:0] e_dest;
        logic          e_tail;
        logic [FW-1:0] e_data;
        idx    = 0;
        e_dest = '0;
        e_tail = 1'b0;
        #1;
        check_val({tag, " pop_out"}, 64'(bus.pop_out), 64'(exp_pop));
        for (int i = 0; i < NI; i++) begin
            if (exp_pop[i]) idx = i;
        end
        if (exp_pop != '0) begin
            exp_q.push_back(flit_data[idx]);
            e_dest = flit_dest[idx];
            e_tail = bus.is_tail_in[idx];
        end
        @(posedge clk_noc);
        #1;
        check_val({tag, " send_out"}, 64'(bus.send_out), 64'(exp_pop != '0));
        if (exp_pop != '0) begin
            e_data = exp_q.pop_front();
            check_val({tag, " data_out"}, bus.data_out, e_data);
            check_val({tag, " dest_out"}, 64'(bus.dest_out), 64'(e_dest));
            check_val({tag, " is_tail_out"}, 64'(bus.is_tail_out), 64'(e_tail));
            check_val({tag, " grant_idx"}, 64'(bus.grant_idx), 64'(idx));
            last_data = e_data;
        end else begin
            check_val({tag, " data_out hold"}, bus.data_out, last_data);
        end
    endtask

    // ---------------- directed vectors ----------------
    logic [NI-1:0] t2_exp [6];
    logic [NI-1:0] t3_req [5];
    logic [NI-1:0] t3_tail [5];
    logic [NI-1:0] t3_exp [5];
    logic          t3_lock [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        seq       = 0;
        last_data = '0;
        t2_exp  = '{5'b00001, 5'b00100, 5'b01000, 5'b00001, 5'b00100, 5'b01000};
        t3_req  = '{5'b00110, 5'b00110, 5'b00100, 5'b00110, 5'b00100};
        t3_tail = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00100};
        t3_exp  = '{5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00100};
        t3_lock = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Power-on reset values, pop held off while in reset.
        rst_noc = 1'b1;
        drive('0, '0, 1'b0);
        @(posedge clk_noc);
        #1;
        check_val("rst credits_avail", 64'(bus.credits_avail), 64'd8);
        check_val("rst send_out", 64'(bus.send_out), 64'd0);
        check_val("rst locked_out", 64'(bus.locked_out), 64'd0);
        check_val("rst grant_idx", 64'(bus.grant_idx), 64'd0);
        check_val("rst credit_err", 64'(bus.credit_err), 64'd0);
        check_val("rst data_out", bus.data_out, 64'd0);
        drive(5'b11111, 5'b11111, 1'b0);
        #1;
        check_val("rst pop_out gated", 64'(bus.pop_out), 64'd0);
        do_reset();

        // T2: round robin over inputs 0,2,3 with single-flit packets.
        for (int k = 0; k < 6; k++) begin
            drive(5'b01101, 5'b11111, 1'b1);
            run_cycle($sformatf("t2_rr[%0d]", k), t2_exp[k]);
        end
        drive('0, '0, 1'b0);
        check_val("t2 credits_avail", 64'(bus.credits_avail), 64'd8);
        check_val("t2 credit_err", 64'(bus.credit_err), 64'd0);

        // T3: wormhole packet from input 1 with an owner gap; input 2 waits.
        for (int k = 0; k < 5; k++) begin
            drive(t3_req[k], t3_tail[k], 1'b0);
            run_cycle($sformatf("t3_worm[%0d]", k), t3_exp[k]);
            check_val($sformatf("t3 locked_out[%0d]", k), 64'(bus.locked_out), 64'(t3_lock[k]));
        end
        drive('0, '0, 1'b0);
        check_val("t3 credits_avail", 64'(bus.credits_avail), 64'd4);

        // T4: credit exhaustion then a single credit return.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(5'b00001, 5'b00001, 1'b0);
            run_cycle($sformatf("t4_stream[%0d]", k), 5'b00001);
        end
        check_val("t4 credits_avail empty", 64'(bus.credits_avail), 64'd0);
        for (int k = 0; k < 2; k++) begin
            drive(5'b00001, 5'b00001, 1'b0);
            run_cycle($sformatf("t4_stall[%0d]", k), 5'b00000);
        end
        drive(5'b00001, 5'b00001, 1'b1);
        run_cycle("t4_credit_no_bypass", 5'b00000);
        check_val("t4 credits_avail one", 64'(bus.credits_avail), 64'd1);
        drive(5'b00001, 5'b00001, 1'b0);
        run_cycle("t4_ninth", 5'b00001);
        drive(5'b00001, 5'b00001, 1'b0);
        run_cycle("t4_tenth_blocked", 5'b00000);
        check_val("t4 credits_avail end", 64'(bus.credits_avail), 64'd0);

        // T5: credit and pop in the same cycle cancel.
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1'b1);
            run_cycle($sformatf("t5_refill[%0d]", k), 5'b00000);
        end
        check_val("t5 credits_avail three", 64'(bus.credits_avail), 64'd3);
        drive(5'b00001, 5'b00001, 1'b1);
        run_cycle("t5_simul", 5'b00001);
        check_val("t5 credits_avail held", 64'(bus.credits_avail), 64'd3);
        drive('0, '0, 1'b0);

        // T6: credit overflow saturates and sets the sticky error.
        do_reset();
        drive('0, '0, 1'b1);
        run_cycle("t6_overflow", 5'b00000);
        drive('0, '0, 1'b0);
        check_val("t6 credits_avail sat", 64'(bus.credits_avail), 64'd8);
        check_val("t6 credit_err set", 64'(bus.credit_err), 64'd1);
        for (int k = 0; k < 3; k++) begin
            run_cycle($sformatf("t6_idle[%0d]", k), 5'b00000);
        end
        check_val("t6 credit_err sticky", 64'(bus.credit_err), 64'd1);

        // T1: asynchronous reset in the middle of a locked packet.
        drive(5'b00001, 5'b00000, 1'b0);
        run_cycle("t1_head", 5'b00001);
        check_val("t1 locked before reset", 64'(bus.locked_out), 64'd1);
        check_val("t1 credits before reset", 64'(bus.credits_avail), 64'd7);
        #2;
        rst_noc = 1'b1;
        #1;
        check_val("t1 async credits_avail", 64'(bus.credits_avail), 64'd8);
        check_val("t1 async send_out", 64'(bus.send_out), 64'd0);
        check_val("t1 async locked_out", 64'(bus.locked_out), 64'd0);
        check_val("t1 async credit_err", 64'(bus.credit_err), 64'd0);
        check_val("t1 async data_out", bus.data_out, 64'd0);
        check_val("t1 async pop_out", 64'(bus.pop_out), 64'd0);
        @(posedge clk_noc);
        #1;
        rst_noc   = 1'b0;
        last_data = '0;
        exp_q.delete();
        // Lock abandoned: a different input wins right away.
        drive(5'b00010, 5'b00010, 1'b0);
        run_cycle("t1_after_reset", 5'b00010);
        check_val("t1 locked after", 64'(bus.locked_out), 64'd0);
        drive('0, '0, 1'b0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
